// File: rtl/vgg_ddr_pkg.sv
// Shared DDR-side definitions for the VGG accelerator: command codes, bus widths
// and the FC read-controller state encoding.
package vgg_ddr_pkg;

    localparam int unsigned DDR_ADDR_W = 30;
    localparam int unsigned DDR_DATA_W = 512;

    localparam logic [2:0] DDR_CMD_RD = 3'b001;
    localparam logic [2:0] DDR_CMD_WR = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fc_rd_state_t;

endpackage

// File: rtl/sync_fifo_512.sv
// Synchronous 512-bit FIFO with occupancy count; head word is presented
// combinationally and forced to zero while empty.
module sync_fifo_512 #(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [511:0]     push_data,
    input  logic             pop,
    output logic [511:0]     pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [511:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = pop && !empty;
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (push && !w_do_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!push && w_do_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= push_data;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (r_count == CNT_W'(DEPTH))))
        else $error("sync_fifo_512: push while full");

endmodule

// File: rtl/fc_ddr_rd_ctrl.sv
// FC-engine DDR read client: wins the arbiter's FC port, issues a credit-limited
// run of read commands and streams returned beats out through a return FIFO.
module fc_ddr_rd_ctrl
    import vgg_ddr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned ADDR_STEP  = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    input  logic [DDR_ADDR_W-1:0] rd_base_addr,
    input  logic [LEN_W-1:0]      rd_num_words,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  arb_fc_req,
    input  logic                  arb_fc_grant,
    output logic [DDR_ADDR_W-1:0] arb_fc_addr,
    output logic [2:0]            arb_fc_cmd,
    output logic                  arb_fc_en,
    input  logic                  ddr_rdy,
    input  logic                  ddr_rd_data_valid,
    input  logic [DDR_DATA_W-1:0] ddr_rd_data,
    output logic [DDR_DATA_W-1:0] fc_data,
    output logic                  fc_valid,
    input  logic                  fc_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fc_rd_state_t          r_state;
    logic [DDR_ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_outstanding;
    logic                  r_req;
    logic                  r_busy;
    logic                  r_done;

    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W-1:0]      w_out_nxt;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_credit_ok;
    logic                  w_en;
    logic                  w_accept;

    assign w_push      = ddr_rd_data_valid && (r_state != ST_IDLE);
    // Reserve FIFO space for every beat already in flight before issuing another.
    assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign w_en        = (r_state == ST_ISSUE) && arb_fc_grant && w_credit_ok && (r_issued < r_len);
    assign w_accept    = w_en && ddr_rdy;

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_accept && !w_push)
            w_out_nxt = r_outstanding + CNT_W'(1);
        else if (!w_accept && w_push)
            w_out_nxt = r_outstanding - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_req         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (rd_start) begin
                        r_addr   <= rd_base_addr;
                        r_len    <= rd_num_words;
                        r_issued <= '0;
                        r_busy   <= 1'b1;
                        if (rd_num_words == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (arb_fc_grant)
                        r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_accept) begin
                        r_addr   <= r_addr + DDR_ADDR_W'(ADDR_STEP);
                        r_issued <= r_issued + LEN_W'(1);
                        if ((r_issued + LEN_W'(1)) == r_len)
                            r_state <= ST_DRAIN;
                    end
                end
                // Hold the port until every return has landed.
                ST_DRAIN: begin
                    if (w_out_nxt == '0) begin
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo_512 #(
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (ddr_rd_data),
        .pop       (fc_ready),
        .pop_data  (fc_data),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign fc_valid    = !w_fifo_empty;
    assign arb_fc_req  = r_req;
    assign arb_fc_en   = w_en;
    assign arb_fc_addr = r_addr;
    assign arb_fc_cmd  = DDR_CMD_RD;
    assign rd_busy     = r_busy;
    assign rd_done     = r_done;

endmodule
